pktunit_tx_arbiter: RTL

Packet-atomic round-robin arbiter that shares one packet-unit (PU) transmit poller between NUM_PORTS PU sources. Each source presents the data/flags/eop triplet used by the poller. One source is granted per frame, and its beats pass through to the poller until the beat carrying a nonzero eop is accepted. The block sits between the per-source frame builders and the single raw-socket poller instance, and keeps per-port frame counters.

---
 rtl/pktunit_tx_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pktunit_tx_arbiter.sv
// Packet-atomic round-robin arbiter: one source at a time owns the PU poller
// from arbitration until its eop beat is accepted; counts completed frames per port.
module pktunit_tx_arbiter #(
  parameter int DATA_BYTES = 8,
  parameter int NUM_PORTS  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]    s_data_d,
  input  logic [NUM_PORTS-1:0]                 s_data_v,
  output logic [NUM_PORTS-1:0]                 s_data_r,
  input  logic [NUM_PORTS*8-1:0]               s_flags_d,
  input  logic [NUM_PORTS-1:0]                 s_flags_v,
  output logic [NUM_PORTS-1:0]                 s_flags_r,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]      s_eop_d,
  input  logic [NUM_PORTS-1:0]                 s_eop_v,
  output logic [NUM_PORTS-1:0]                 s_eop_r,
  output logic [DATA_BYTES*8-1:0]              m_data_d,
  output logic                                 m_data_v,
  input  logic                                 m_data_r,
  output logic [7:0]                           m_flags_d,
  output logic                                 m_flags_v,
  input  logic                                 m_flags_r,
  output logic [DATA_BYTES-1:0]                m_eop_d,
  output logic                                 m_eop_v,
  input  logic                                 m_eop_r,
  input  logic [NUM_PORTS-1:0]                 port_en,
  output logic                                 grant_v,
  output logic [$clog2(NUM_PORTS)-1:0]         grant_id,
  output logic [NUM_PORTS*CNT_W-1:0]           frame_cnt
);

  localparam int DW   = DATA_BYTES * 8;
  localparam int ID_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                     state_q, state_d;
  logic [ID_W-1:0]            grant_id_q, grant_id_d;
  logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS*CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic [NUM_PORTS-1:0] in_v;
  logic [NUM_PORTS-1:0] req;
  logic                 m_rdy;
  logic                 xfer;
  logic                 found;
  logic [ID_W-1:0]      winner;

  assign in_v  = s_data_v & s_flags_v & s_eop_v;
  assign req   = in_v & port_en;
  assign m_rdy = m_data_r & m_flags_r & m_eop_r;

  // First requester at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin : rr_search
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin : datapath
    m_data_d  = '0;
    m_flags_d = '0;
    m_eop_d   = '0;
    m_data_v  = 1'b0;
    m_flags_v = 1'b0;
    m_eop_v   = 1'b0;
    s_data_r  = '0;
    s_flags_r = '0;
    s_eop_r   = '0;
    if (state_q == LOCK) begin
      m_data_d             = s_data_d[int'(grant_id_q)*DW +: DW];
      m_flags_d            = s_flags_d[int'(grant_id_q)*8 +: 8];
      m_eop_d              = s_eop_d[int'(grant_id_q)*DATA_BYTES +: DATA_BYTES];
      m_data_v             = in_v[grant_id_q];
      m_flags_v            = in_v[grant_id_q];
      m_eop_v              = in_v[grant_id_q];
      s_data_r[grant_id_q]  = m_rdy;
      s_flags_r[grant_id_q] = m_rdy;
      s_eop_r[grant_id_q]   = m_rdy;
    end
  end

  assign xfer = (state_q == LOCK) && in_v[grant_id_q] && m_rdy;

  always_comb begin : next_state
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = LOCK;
          grant_id_d = winner;
        end
      end
      LOCK: begin
        // The frame ends only when its eop beat is actually accepted.
        if (xfer && (|m_eop_d)) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_id_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_id_q + 1'b1;
          frame_cnt_d[int'(grant_id_q)*CNT_W +: CNT_W] =
            frame_cnt_q[int'(grant_id_q)*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      // NOTE: the frame counters are plain flops, not a RAM, so clearing them on reset is cheap and required.
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign grant_v   = (state_q == LOCK);
  assign grant_id  = grant_id_q;
  assign frame_cnt = frame_cnt_q;

endmodule
